// File: rtl/image_pipe_reg_pkg.sv
// Shared register-map constants, reset values and register index type
// for the image pipe register block.
package image_pipe_reg_pkg;

    localparam logic [7:0] OFF_CTRL      = 8'h00;
    localparam logic [7:0] OFF_IMG_SIZE  = 8'h04;
    localparam logic [7:0] OFF_THRESH    = 8'h08;
    localparam logic [7:0] OFF_STATUS    = 8'h0C;
    localparam logic [7:0] OFF_INT_STAT  = 8'h10;
    localparam logic [7:0] OFF_INT_EN    = 8'h14;
    localparam logic [7:0] OFF_FRAME_CNT = 8'h18;
    localparam logic [7:0] OFF_VERSION   = 8'h1C;

    localparam logic [15:0] RST_WIDTH  = 16'd640;
    localparam logic [15:0] RST_HEIGHT = 16'd480;
    localparam logic [7:0]  RST_THRESH = 8'd128;

    localparam logic [31:0] VERSION_VAL = 32'h0001_0200;

    typedef enum logic [2:0] {
        REG_CTRL      = 3'd0,
        REG_IMG_SIZE  = 3'd1,
        REG_THRESH    = 3'd2,
        REG_STATUS    = 3'd3,
        REG_INT_STAT  = 3'd4,
        REG_INT_EN    = 3'd5,
        REG_FRAME_CNT = 3'd6,
        REG_VERSION   = 3'd7
    } reg_idx_e;

endpackage

// File: rtl/image_pipe_reg_rd_pipe.sv
// RD_LAT-deep read-data delay line; data captured at request time and
// held at the output between valid pulses.
module image_pipe_reg_rd_pipe #(
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          reg_cpu_clk,
    input  logic          rst,
    input  logic          req_vld,
    input  logic [DW-1:0] req_data,
    output logic          rdv,
    output logic [DW-1:0] rd_data
);

    logic [RD_LAT-1:0] vld;
    logic [DW-1:0]     data [RD_LAT];

    // Each data stage only loads behind a valid, so bubbles never overwrite
    // the last delivered word.
    always_ff @(posedge reg_cpu_clk) begin
        if (rst) begin
            vld <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) data[i] <= '0;
        end else begin
            vld[0] <= req_vld;
            if (req_vld) data[0] <= req_data;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) data[i] <= data[i-1];
            end
        end
    end

    assign rdv     = vld[RD_LAT-1];
    assign rd_data = data[RD_LAT-1];

endmodule

// File: rtl/image_pipe_reg_blk.sv
// Image pipe register block: CPU bus decode, double-buffered geometry and
// threshold, status, interrupts and frame counter.
module image_pipe_reg_blk
    import image_pipe_reg_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned AW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          reg_cpu_clk,
    input  logic          rst,
    input  logic          reg_cpu_cs,
    input  logic [AW-1:0] reg_cpu_addr,
    input  logic [DW-1:0] reg_cpu_wr_data,
    input  logic          reg_cpu_we,
    input  logic          reg_cpu_re,
    output logic [DW-1:0] reg_cpu_rd_data,
    output logic          reg_cpu_rdv,
    input  logic          pipe_frame_start,
    input  logic          pipe_frame_done,
    input  logic          pipe_overflow,
    input  logic          pipe_busy,
    output logic          cfg_enable,
    output logic          cfg_soft_rst,
    output logic [15:0]   cfg_width,
    output logic [15:0]   cfg_height,
    output logic [7:0]    cfg_thresh,
    output logic          irq
);

    logic        mapped;
    reg_idx_e    sel;
    logic        wr_en;
    logic        rd_req;
    logic [15:0] stg_width;
    logic [15:0] stg_height;
    logic [7:0]  stg_thresh;
    logic        shadow_pending;
    logic [1:0]  int_stat;
    logic [1:0]  int_en;
    logic [15:0] frame_cnt;
    logic [1:0]  w1c_mask;
    logic [1:0]  int_set;
    logic [DW-1:0] rd_mux;

    assign mapped   = (reg_cpu_addr[AW-1:5] == '0);
    assign sel      = reg_idx_e'(reg_cpu_addr[4:2]);
    assign wr_en    = reg_cpu_cs & reg_cpu_we & mapped;
    assign rd_req   = reg_cpu_cs & reg_cpu_re & ~reg_cpu_we;
    assign w1c_mask = (wr_en && sel == REG_INT_STAT) ? reg_cpu_wr_data[1:0] : 2'b00;
    assign int_set  = {pipe_overflow, pipe_frame_done};

    // Commit is assigned before the staging write so a coincident write
    // re-stages its value and keeps shadow_pending set.
    always_ff @(posedge reg_cpu_clk) begin
        if (rst) begin
            cfg_enable     <= 1'b0;
            cfg_soft_rst   <= 1'b0;
            stg_width      <= RST_WIDTH;
            stg_height     <= RST_HEIGHT;
            stg_thresh     <= RST_THRESH;
            cfg_width      <= RST_WIDTH;
            cfg_height     <= RST_HEIGHT;
            cfg_thresh     <= RST_THRESH;
            shadow_pending <= 1'b0;
            int_stat       <= '0;
            int_en         <= '0;
            frame_cnt      <= '0;
            irq            <= 1'b0;
        end else begin
            cfg_soft_rst <= 1'b0;
            if (pipe_frame_start) begin
                cfg_width      <= stg_width;
                cfg_height     <= stg_height;
                cfg_thresh     <= stg_thresh;
                shadow_pending <= 1'b0;
            end
            if (wr_en) begin
                unique case (sel)
                    REG_CTRL: begin
                        cfg_enable   <= reg_cpu_wr_data[0];
                        cfg_soft_rst <= reg_cpu_wr_data[1];
                    end
                    REG_IMG_SIZE: begin
                        stg_width      <= reg_cpu_wr_data[15:0];
                        stg_height     <= reg_cpu_wr_data[31:16];
                        shadow_pending <= 1'b1;
                    end
                    REG_THRESH: begin
                        stg_thresh     <= reg_cpu_wr_data[7:0];
                        shadow_pending <= 1'b1;
                    end
                    REG_INT_EN: int_en <= reg_cpu_wr_data[1:0];
                    default: ;
                endcase
            end
            int_stat <= (int_stat & ~w1c_mask) | int_set;
            if (pipe_frame_done) frame_cnt <= frame_cnt + 16'd1;
            irq <= |(int_stat & int_en);
        end
    end

    always_comb begin
        rd_mux = '0;
        if (mapped) begin
            unique case (sel)
                REG_CTRL:      rd_mux[0]     = cfg_enable;
                REG_IMG_SIZE:  rd_mux        = {stg_height, stg_width};
                REG_THRESH:    rd_mux[7:0]   = stg_thresh;
                REG_STATUS:    rd_mux[1:0]   = {shadow_pending, pipe_busy};
                REG_INT_STAT:  rd_mux[1:0]   = int_stat;
                REG_INT_EN:    rd_mux[1:0]   = int_en;
                REG_FRAME_CNT: rd_mux[15:0]  = frame_cnt;
                REG_VERSION:   rd_mux        = VERSION_VAL;
                default: ;
            endcase
        end
    end

    image_pipe_reg_rd_pipe #(
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .reg_cpu_clk (reg_cpu_clk),
        .rst         (rst),
        .req_vld     (rd_req),
        .req_data    (rd_mux),
        .rdv         (reg_cpu_rdv),
        .rd_data     (reg_cpu_rd_data)
    );

endmodule

// File: tb/tb_image_pipe_reg_blk.sv
// Scoreboard bench for image_pipe_reg_blk: reads push expected words,
// a negedge monitor pops and checks data and latency on every rdv.
module tb_image_pipe_reg_blk;

    localparam int unsigned LAT = 3;
    localparam logic [31:0] VERSION_EXP = 32'h0001_0200;

    logic        reg_cpu_clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_cpu_cs = 1'b0;
    logic [31:0] reg_cpu_addr = '0;
    logic [31:0] reg_cpu_wr_data = '0;
    logic        reg_cpu_we = 1'b0;
    logic        reg_cpu_re = 1'b0;
    logic [31:0] reg_cpu_rd_data;
    logic        reg_cpu_rdv;
    logic        pipe_frame_start = 1'b0;
    logic        pipe_frame_done = 1'b0;
    logic        pipe_overflow = 1'b0;
    logic        pipe_busy = 1'b0;
    logic        cfg_enable;
    logic        cfg_soft_rst;
    logic [15:0] cfg_width;
    logic [15:0] cfg_height;
    logic [7:0]  cfg_thresh;
    logic        irq;

    image_pipe_reg_blk #(
        .DW     (32),
        .AW     (32),
        .RD_LAT (LAT)
    ) dut (
        .reg_cpu_clk     (reg_cpu_clk),
        .rst             (rst),
        .reg_cpu_cs      (reg_cpu_cs),
        .reg_cpu_addr    (reg_cpu_addr),
        .reg_cpu_wr_data (reg_cpu_wr_data),
        .reg_cpu_we      (reg_cpu_we),
        .reg_cpu_re      (reg_cpu_re),
        .reg_cpu_rd_data (reg_cpu_rd_data),
        .reg_cpu_rdv     (reg_cpu_rdv),
        .pipe_frame_start(pipe_frame_start),
        .pipe_frame_done (pipe_frame_done),
        .pipe_overflow   (pipe_overflow),
        .pipe_busy       (pipe_busy),
        .cfg_enable      (cfg_enable),
        .cfg_soft_rst    (cfg_soft_rst),
        .cfg_width       (cfg_width),
        .cfg_height      (cfg_height),
        .cfg_thresh      (cfg_thresh),
        .irq             (irq)
    );

    always #5 reg_cpu_clk = ~reg_cpu_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rdv_seen = 0;

    always @(posedge reg_cpu_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    always @(negedge reg_cpu_clk) begin
        if (reg_cpu_rdv === 1'b1) begin
            exp_t e;
            rdv_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rdv: got rd_data 0x%08h at cycle %0d, no read outstanding",
                         reg_cpu_rd_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("rd_data@0x%02h", e.addr), reg_cpu_rd_data, e.data);
                check($sformatf("rd_lat@0x%02h", e.addr), cyc, e.due);
            end
        end
    end

    task automatic tick();
        @(posedge reg_cpu_clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        reg_cpu_cs = 1'b1; reg_cpu_we = 1'b1; reg_cpu_addr = a; reg_cpu_wr_data = d;
        tick();
        reg_cpu_cs = 1'b0; reg_cpu_we = 1'b0;
    endtask

    // Read data becomes visible at the negedge RD_LAT cycles after sampling.
    task automatic bus_read_issue(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        reg_cpu_cs = 1'b1; reg_cpu_re = 1'b1; reg_cpu_addr = a;
        e.addr = a; e.data = d; e.due = cyc + LAT;
        exp_q.push_back(e);
        tick();
        reg_cpu_cs = 1'b0; reg_cpu_re = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d reads outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] d);
        bus_read_issue(a, d);
        drain();
    endtask

    task automatic pulse_frame_start();
        pipe_frame_start = 1'b1; tick(); pipe_frame_start = 1'b0;
    endtask

    task automatic pulse_frame_done();
        pipe_frame_done = 1'b1; tick(); pipe_frame_done = 1'b0;
    endtask

    initial begin
        int rdv_before;
        repeat (3) tick();
        check("rst_cfg_width", {16'h0, cfg_width}, 32'd640);
        check("rst_cfg_height", {16'h0, cfg_height}, 32'd480);
        check("rst_cfg_thresh", {24'h0, cfg_thresh}, 32'd128);
        check("rst_outs", {27'h0, cfg_enable, cfg_soft_rst, irq, reg_cpu_rdv, 1'b0}, 32'h0);
        check("rst_rd_data", reg_cpu_rd_data, 32'h0);
        rst = 1'b0;
        tick();

        // Back-to-back reads of the whole map
        bus_read_issue(32'h00, 32'h0);
        bus_read_issue(32'h04, 32'h01E0_0280);
        bus_read_issue(32'h08, 32'h80);
        bus_read_issue(32'h0C, 32'h0);
        bus_read_issue(32'h10, 32'h0);
        bus_read_issue(32'h14, 32'h0);
        bus_read_issue(32'h18, 32'h0);
        bus_read_issue(32'h1C, VERSION_EXP);
        drain();
        tick();
        check("rd_data_hold", reg_cpu_rd_data, VERSION_EXP);

        // Geometry double buffering
        bus_write(32'h04, 32'h0438_0780);
        check("width_staged_only", {16'h0, cfg_width}, 32'd640);
        bus_read(32'h0C, 32'h2);
        pulse_frame_start();
        check("width_commit", {16'h0, cfg_width}, 32'd1920);
        check("height_commit", {16'h0, cfg_height}, 32'd1080);
        bus_read(32'h0C, 32'h0);
        bus_read(32'h05, 32'h0438_0780);

        // THRESH write coincident with frame_start
        reg_cpu_cs = 1'b1; reg_cpu_we = 1'b1; reg_cpu_addr = 32'h08; reg_cpu_wr_data = 32'h40;
        pipe_frame_start = 1'b1;
        tick();
        reg_cpu_cs = 1'b0; reg_cpu_we = 1'b0; pipe_frame_start = 1'b0;
        check("thresh_not_committed", {24'h0, cfg_thresh}, 32'd128);
        bus_read(32'h0C, 32'h2);
        bus_read(32'h08, 32'h40);
        pulse_frame_start();
        check("thresh_commit", {24'h0, cfg_thresh}, 32'd64);

        // Interrupts and frame counter
        bus_write(32'h14, 32'h3);
        pulse_frame_done();
        check("irq_lags_stat", {31'h0, irq}, 32'h0);
        tick();
        check("irq_set", {31'h0, irq}, 32'h1);
        bus_read(32'h10, 32'h1);
        bus_read(32'h18, 32'h1);
        reg_cpu_cs = 1'b1; reg_cpu_we = 1'b1; reg_cpu_addr = 32'h10; reg_cpu_wr_data = 32'h1;
        pipe_frame_done = 1'b1;
        tick();
        reg_cpu_cs = 1'b0; reg_cpu_we = 1'b0; pipe_frame_done = 1'b0;
        bus_read(32'h10, 32'h1);
        bus_write(32'h10, 32'h1);
        tick();
        check("irq_clear", {31'h0, irq}, 32'h0);
        bus_read(32'h10, 32'h0);
        bus_read(32'h18, 32'h2);
        pipe_overflow = 1'b1; tick(); pipe_overflow = 1'b0;
        bus_read(32'h10, 32'h2);
        bus_write(32'h10, 32'h2);
        bus_read(32'h10, 32'h0);

        // Unmapped, RO writes, CTRL
        bus_read(32'h40, 32'h0);
        bus_write(32'h44, 32'hFFFF_FFFF);
        bus_read(32'h04, 32'h0438_0780);
        pipe_busy = 1'b1;
        bus_write(32'h0C, 32'hFFFF_FFFF);
        bus_read(32'h0C, 32'h1);
        pipe_busy = 1'b0;
        check("soft_rst_idle", {31'h0, cfg_soft_rst}, 32'h0);
        bus_write(32'h00, 32'h3);
        check("ctrl_enable", {31'h0, cfg_enable}, 32'h1);
        check("soft_rst_pulse", {31'h0, cfg_soft_rst}, 32'h1);
        tick();
        check("soft_rst_drop", {31'h0, cfg_soft_rst}, 32'h0);
        bus_read(32'h00, 32'h1);

        // we and re together: write only
        reg_cpu_cs = 1'b1; reg_cpu_we = 1'b1; reg_cpu_re = 1'b1;
        reg_cpu_addr = 32'h14; reg_cpu_wr_data = 32'h1;
        rdv_before = rdv_seen;
        tick();
        reg_cpu_cs = 1'b0; reg_cpu_we = 1'b0; reg_cpu_re = 1'b0;
        repeat (LAT + 2) tick();
        check("we_re_no_rdv", rdv_seen - rdv_before, 32'h0);
        bus_read(32'h14, 32'h1);

        // Reset with reads in flight
        rdv_before = rdv_seen;
        reg_cpu_cs = 1'b1; reg_cpu_re = 1'b1; reg_cpu_addr = 32'h1C;
        tick();
        reg_cpu_addr = 32'h04;
        tick();
        rst = 1'b1;
        reg_cpu_addr = 32'h08;
        tick();
        reg_cpu_addr = 32'h18;
        tick();
        reg_cpu_cs = 1'b0; reg_cpu_re = 1'b0;
        rst = 1'b0;
        repeat (LAT + 4) tick();
        check("no_rdv_after_rst", rdv_seen - rdv_before, 32'h0);
        check("rd_data_after_rst", reg_cpu_rd_data, 32'h0);
        check("width_after_rst", {16'h0, cfg_width}, 32'd640);

        // Frame counter wrap
        pipe_frame_done = 1'b1;
        repeat (16'hFFFF) tick();
        pipe_frame_done = 1'b0;
        bus_read(32'h18, 32'h0000_FFFF);
        pulse_frame_done();
        bus_read(32'h18, 32'h0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/image_pipe_reg_blk.md
# image_pipe_reg_blk

Register block for the image pipe that terminates the CPU register bus (cs/addr/we/re/wr_data in, rd_data/rdv out) and decodes accesses into pipe configuration, status and interrupt registers. It sits directly downstream of the CPU register bus interface and drives the image pipe's configuration inputs. Geometry and threshold are double-buffered: they apply only at frame boundaries.

## Interface
- DW, 32, data width; only 32 supported
- AW, 32, address width
- RD_LAT, 1, read latency in cycles, legal 1..4
- reg_cpu_clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- reg_cpu_cs  in  1  chip select; access valid only when high
- reg_cpu_addr  in  AW  byte address
- reg_cpu_wr_data  in  DW  write data
- reg_cpu_we  in  1  write strobe
- reg_cpu_re  in  1  read strobe
- reg_cpu_rd_data  out  DW  read data, valid when rdv=1
- reg_cpu_rdv  out  1  read-data-valid, one-cycle pulse per read
- pipe_frame_start  in  1  pulse; commits shadow registers
- pipe_frame_done  in  1  pulse; sets INT_STAT[0], increments FRAME_CNT
- pipe_overflow  in  1  pulse; sets INT_STAT[1]
- pipe_busy  in  1  level, mirrored in STATUS[0]
- cfg_enable  out  1  CTRL[0]
- cfg_soft_rst  out  1  one-cycle pulse on a write of CTRL[1]=1
- cfg_width  out  16  active width
- cfg_height  out  16  active height
- cfg_thresh  out  8  active threshold
- irq  out  1  registered OR of INT_STAT & INT_EN

## Operation
- Decode: addr[4:2] selects a register; addr[1:0] ignored; addr[AW-1:5]!=0 is unmapped (writes dropped, reads return 0).
- Map: 0x00 CTRL RW (bit0 enable; bit1 soft_rst, self-clearing, reads 0); 0x04 IMG_SIZE RW shadowed ([15:0] width, [31:16] height); 0x08 THRESH RW shadowed ([7:0]); 0x0C STATUS RO (bit0 pipe_busy, bit1 shadow_pending); 0x10 INT_STAT W1C [1:0]; 0x14 INT_EN RW [1:0]; 0x18 FRAME_CNT RO [15:0]; 0x1C VERSION RO constant.
- Unused bits read 0; writes to RO registers are ignored.
- Shadowing: a write to IMG_SIZE/THRESH updates the staged copy and sets shadow_pending. On pipe_frame_start the staged values are copied to the cfg_* outputs and shadow_pending clears. Reads return the staged copy.
- Write on the same cycle as frame_start: the commit uses pre-write staged values; the new write stays staged and shadow_pending stays 1.
- INT_STAT: a set pulse on the same cycle as a W1C of that bit leaves the bit set.
- FRAME_CNT: 16-bit counter, wraps 0xFFFF->0; not clearable except by reset.
- cs&we&re together: write only, no rdv.
- Reset values: CTRL=0; staged and active width=640, height=480, thresh=128; INT_STAT=0; INT_EN=0; FRAME_CNT=0; rd_data=0; rdv=0; irq=0; cfg_soft_rst=0.

## Timing
- Writes take effect on the clock edge where cs&we are sampled; RW readback is valid from the next cycle.
- Read: rd_data/rdv appear exactly RD_LAT cycles after cs&re is sampled. Data is captured at the sample cycle and not re-sampled later.
- Back-to-back reads are fully pipelined: one rdv per read, in order. rd_data holds its last value when rdv=0.
- irq updates 1 cycle after INT_STAT or INT_EN change.
- cfg_soft_rst goes high the cycle after the write and lasts 1 cycle.
- Reset mid-read: pending reads are discarded and no rdv is emitted after reset.

## Structure
- Package image_pipe_reg_pkg holds the register offset localparams, field reset constants (640/480/128), VERSION value, and an enum for register index.
- One sub-module, image_pipe_reg_rd_pipe: a parameterised RD_LAT-deep valid/data delay line with synchronous reset.

## Test plan
- Reset, read all 8 registers -> IMG_SIZE=0x01E0_0280, THRESH=0x80, VERSION constant, others 0; each rdv exactly RD_LAT cycles after re.
- Write IMG_SIZE=0x0438_0780 -> cfg_width stays 640, STATUS[1]=1; pulse frame_start -> cfg_width=1920, cfg_height=1080, STATUS[1]=0.
- Write THRESH=0x40 in the same cycle as frame_start -> cfg_thresh stays 128, STATUS[1]=1; next frame_start -> cfg_thresh=64.
- INT_EN=0x3, pulse frame_done -> INT_STAT=0x1, irq=1, FRAME_CNT=1; W1C 0x1 in the same cycle as a frame_done pulse -> bit stays 1; a later W1C clears it -> irq=0.
- Read unmapped 0x40 -> rd_data=0, rdv=1; write 0x0C with 0xFFFFFFFF -> STATUS unchanged; write CTRL=0x3 -> cfg_enable=1, one-cycle cfg_soft_rst, CTRL reads 0x1.
- Four back-to-back reads with RD_LAT=3, reset asserted after the second -> exactly 0 rdv after reset; 0x10000 frame_done pulses -> FRAME_CNT wraps to 0.
